// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO read-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_BURST   = 4;
  localparam int DEF_TIMEOUT = 16;

  // Requester index reached by stepping 'offset' places past 'last_idx', wrapping at nreq.
  function automatic int rr_idx(input int last_idx, input int offset, input int nreq);
    return (last_idx + offset) % nreq;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: search starts one past the
// last served requester and wraps, so the last winner has lowest priority.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_gnt,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int IW = $clog2(NREQ);

  logic found_s;

  // First asserted request in rotated priority order wins; nothing wins when req is zero.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found_s = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      int idx_v;
      idx_v = rr_idx(int'(last_gnt), off, NREQ);
      if (!found_s && req[IW'(idx_v)]) begin
        win[IW'(idx_v)] = 1'b1;
        win_idx         = IW'(idx_v);
        found_s         = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter handing the FIFO read port to one requester at a time
// for a burst of BURST beats, aborting the grant if the FIFO stays empty
// for TIMEOUT consecutive cycles.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int BURST   = DEF_BURST,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  input  logic [NREQ-1:0]              req,
  input  logic                         fifo_Empty,
  output logic                         rd_en,
  output logic [NREQ-1:0]              gnt,
  output logic                         busy,
  output logic                         done,
  output logic                         abort,
  output logic [$clog2(BURST+1)-1:0]   beat_cnt
);

  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(NREQ);

  arb_state_e      state_r;
  logic [NREQ-1:0] gnt_r;
  logic [IW-1:0]   last_gnt_r;
  logic [IW-1:0]   served_idx_r;
  logic [BW-1:0]   beat_r;
  logic [TW-1:0]   starv_r;
  logic            busy_r;
  logic            done_r;
  logic            abort_r;

  logic [NREQ-1:0] win_s;
  logic [IW-1:0]   win_idx_s;
  logic            rd_en_s;
  logic [TW-1:0]   starv_inc_s;

  rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .req      (req),
    .last_gnt (last_gnt_r),
    .win      (win_s),
    .win_idx  (win_idx_s)
  );

  // Read strobe follows FIFO availability only while a grant is active.
  always_comb begin
    if (state_r == XFER) begin
      rd_en_s = !fifo_Empty;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  assign starv_inc_s = starv_r + TW'(1);

  // Arbitration FSM with burst and starvation counters; all outputs except rd_en are registered.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_r      <= IDLE;
      gnt_r        <= '0;
      last_gnt_r   <= IW'(NREQ - 1);
      served_idx_r <= '0;
      beat_r       <= '0;
      starv_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          abort_r <= 1'b0;
          beat_r  <= '0;
          starv_r <= '0;
          if (|req) begin
            gnt_r        <= win_s;
            served_idx_r <= win_idx_s;
            busy_r       <= 1'b1;
            state_r      <= XFER;
          end else begin
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        XFER: begin
          // The granted request is not re-sampled here: a grant runs to completion or timeout.
          if (rd_en_s) begin
            beat_r  <= beat_r + BW'(1);
            starv_r <= '0;
            if (beat_r == BW'(BURST - 1)) begin
              done_r  <= 1'b1;
              gnt_r   <= '0;
              state_r <= RELEASE;
            end else begin
              state_r <= XFER;
            end
          end else begin
            starv_r <= starv_inc_s;
            if (starv_inc_s == TW'(TIMEOUT)) begin
              abort_r <= 1'b1;
              gnt_r   <= '0;
              state_r <= RELEASE;
            end else begin
              state_r <= XFER;
            end
          end
        end

        RELEASE: begin
          done_r     <= 1'b0;
          abort_r    <= 1'b0;
          gnt_r      <= '0;
          last_gnt_r <= served_idx_r;
          beat_r     <= '0;
          starv_r    <= '0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          done_r  <= 1'b0;
          abort_r <= 1'b0;
          gnt_r   <= '0;
          beat_r  <= '0;
          starv_r <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rd_en    = rd_en_s;
  assign gnt      = gnt_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign abort    = abort_r;
  assign beat_cnt = beat_r;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter (NREQ=4, BURST=4, TIMEOUT=16).
// Stimulus pushes the expected end-of-grant record; a monitor pops and
// compares it whenever the DUT pulses done or abort.
module tb_fifo_rd_arbiter;

  logic       rd_clk;
  logic       rd_rst;
  logic [3:0] req;
  logic       fifo_Empty;
  logic       rd_en;
  logic [3:0] gnt;
  logic       busy;
  logic       done;
  logic       abort;
  logic [2:0] beat_cnt;

  typedef struct packed {
    logic [3:0] served;
    logic       is_abort;
    logic [2:0] beats;
  } exp_t;

  exp_t exp_q[$];
  int   n_total  = 0;
  int   n_pass   = 0;
  int   n_events = 0;

  fifo_rd_arbiter #(
    .NREQ    (4),
    .BURST   (4),
    .TIMEOUT (16)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .req        (req),
    .fifo_Empty (fifo_Empty),
    .rd_en      (rd_en),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .abort      (abort),
    .beat_cnt   (beat_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [3:0] served, input logic is_abort, input logic [2:0] beats);
    exp_t e;
    e.served   = served;
    e.is_abort = is_abort;
    e.beats    = beats;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge rd_clk);
    #1;
  endtask

  // Monitor: tracks the served grant and issued beats, checks each release against the scoreboard.
  logic [3:0] mon_gnt = 4'd0;
  int         mon_beats = 0;
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      mon_gnt   = 4'd0;
      mon_beats = 0;
      check("rst_no_pulse", 32'({done, abort}), 32'd0);
    end else begin
      if (gnt != 4'd0) mon_gnt = gnt;
      if (rd_en) mon_beats++;
      if (done || abort) begin
        n_events++;
        check("one_of_done_abort", 32'(done ^ abort), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_release", 32'(mon_gnt), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_served", 32'(mon_gnt), 32'(e.served));
          check("sb_abort", 32'(abort), 32'(e.is_abort));
          check("sb_beats", 32'(mon_beats), 32'(e.beats));
        end
        mon_gnt   = 4'd0;
        mon_beats = 0;
      end
    end
  end

  localparam logic [5:0] EMPTY_PAT = 6'b000110;  // bit i = fifo_Empty in XFER cycle i

  initial begin
    rd_rst     = 1'b1;
    req        = 4'd0;
    fifo_Empty = 1'b0;

    // Reset state
    @(negedge rd_clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_beat", 32'(beat_cnt), 32'd0);
    next_cycle();
    rd_rst = 1'b0;

    // Single burst, req dropped right after grant
    req = 4'b0010;
    push(4'b0010, 1'b0, 3'd4);
    next_cycle();
    req = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      check("b_gnt", 32'(gnt), 32'h2);
      check("b_rd_en", 32'(rd_en), 32'd1);
      check("b_beat", 32'(beat_cnt), 32'(i));
      check("b_busy", 32'(busy), 32'd1);
    end
    @(negedge rd_clk);
    check("b_done", 32'(done), 32'd1);
    check("b_rel_gnt", 32'(gnt), 32'd0);
    check("b_rel_rd_en", 32'(rd_en), 32'd0);
    @(negedge rd_clk);
    check("b_idle_busy", 32'(busy), 32'd0);
    check("b_idle_beat", 32'(beat_cnt), 32'd0);
    check("b_idle_done", 32'(done), 32'd0);

    // Round robin from reset with all requesting
    next_cycle();
    rd_rst = 1'b1;
    next_cycle();
    rd_rst = 1'b0;
    begin
      int base;
      int guard;
      base  = n_events;
      guard = 0;
      req   = 4'b1111;
      push(4'b0001, 1'b0, 3'd4);
      push(4'b0010, 1'b0, 3'd4);
      push(4'b0100, 1'b0, 3'd4);
      push(4'b1000, 1'b0, 3'd4);
      push(4'b0001, 1'b0, 3'd4);
      while (n_events < base + 5 && guard < 60) begin
        next_cycle();
        guard++;
      end
      req = 4'd0;
      check("rr_completed", 32'(n_events - base), 32'd5);
    end
    next_cycle();
    next_cycle();

    // Empty toggling during XFER (last served = 0, so only req0 set -> 0001)
    req = 4'b0001;
    push(4'b0001, 1'b0, 3'd4);
    next_cycle();
    req = 4'd0;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] pat_v;
      pat_v      = EMPTY_PAT;
      fifo_Empty = pat_v[i];
      @(negedge rd_clk);
      check("t_rd_en", 32'(rd_en), 32'(!pat_v[i]));
      check("t_no_abort", 32'(abort), 32'd0);
      next_cycle();
    end
    fifo_Empty = 1'b0;
    @(negedge rd_clk);
    check("t_done", 32'(done), 32'd1);
    next_cycle();

    // Starvation timeout
    req        = 4'b0100;
    fifo_Empty = 1'b1;
    push(4'b0100, 1'b1, 3'd0);
    next_cycle();
    req = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge rd_clk);
      check("s_gnt", 32'(gnt), 32'h4);
      check("s_quiet", 32'({rd_en, done, abort}), 32'd0);
      next_cycle();
    end
    @(negedge rd_clk);
    check("s_abort", 32'(abort), 32'd1);
    check("s_no_done", 32'(done), 32'd0);
    check("s_beat", 32'(beat_cnt), 32'd0);
    check("s_rel_gnt", 32'(gnt), 32'd0);
    next_cycle();
    fifo_Empty = 1'b0;
    next_cycle();

    // Asynchronous reset mid-burst
    req = 4'b1000;
    next_cycle();
    req = 4'd0;
    next_cycle();
    next_cycle();
    #2;
    rd_rst = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt), 32'd0);
    check("ar_rd_en", 32'(rd_en), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_beat", 32'(beat_cnt), 32'd0);
    check("ar_pulses", 32'({done, abort}), 32'd0);
    next_cycle();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    check("ar_post_pulses", 32'({done, abort}), 32'd0);
    next_cycle();
    req = 4'b0110;
    push(4'b0010, 1'b0, 3'd4);
    next_cycle();
    req = 4'd0;
    @(negedge rd_clk);
    check("ar_next_gnt", 32'(gnt), 32'h2);
    repeat (7) next_cycle();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
